conv_window_ctrl: RTL and testbench

//  Sequencer in front of the 3x3 conv_unit. Loads and holds nine 3x3 kernel weights
//  (b00..b22), accepts a raster-order pixel stream, and builds sliding 3x3 windows
//  (a00..a22) with two line buffers. Each "valid" window (no padding) is presented to

---
 rtl/conv_window_ctrl_pkg.sv | 28 ++
 rtl/conv_line_buffer.sv | 41 ++++
 rtl/conv_window_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_ctrl_pkg.sv
//==============================================================================
// Module  : conv_window_ctrl_pkg
// Brief   : Shared types and constants for the 3x3 convolution window sequencer
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package conv_window_ctrl_pkg;

    // Number of taps in a 3x3 window / kernel
    localparam int c_TAPS = 9;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Flat tap index of window/kernel element (row, col); a00 -> 0 ... a22 -> 8
    function automatic int tap_index(input int row, input int col);
        return row * 3 + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
//==============================================================================
// Module  : conv_line_buffer
// Brief   : Fixed-depth shift-register line buffer, one push per accepted pixel,
//           tap presents the oldest stored entry
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_line_buffer #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 27
) (
    input  logic             clk,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign mem_d[0] = push ? din : mem_q[0];

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_stage
            assign mem_d[i] = push ? mem_q[i-1] : mem_q[i];
        end
    endgenerate

    // Storage only: contents are don't-care after reset, so no reset branch
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign tap = mem_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/conv_window_ctrl.sv
//==============================================================================
// Module  : conv_window_ctrl
// Brief   : Weight loader and sliding 3x3 window builder feeding conv_unit over
//           a valid/ready handshake, with end-of-frame pulse
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       frame_start,
    input  logic                       w_valid,
    input  logic [WIDTH-1:0]           w_data,
    output logic                       w_ready,
    input  logic                       pix_valid,
    input  logic [WIDTH-1:0]           pix_data,
    output logic                       pix_ready,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*WIDTH-1:0]         win_a,
    output logic [9*WIDTH-1:0]         win_b,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int RW  = $clog2(IMG_H);
    localparam int CW  = $clog2(IMG_W);
    localparam int WCW = $clog2(c_TAPS);

    localparam logic [RW-1:0]  c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]  c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  c_ROW_TWO  = RW'(2);
    localparam logic [CW-1:0]  c_COL_TWO  = CW'(2);
    localparam logic [WCW-1:0] c_W_LAST   = WCW'(c_TAPS - 1);

    state_t           state_q, state_d;
    logic [WCW-1:0]   w_cnt_q, w_cnt_d;
    logic [RW-1:0]    row_q, row_d, out_row_q, out_row_d;
    logic [CW-1:0]    col_q, col_d, out_col_q, out_col_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] wgt_q [c_TAPS];
    logic [WIDTH-1:0] wgt_d [c_TAPS];
    logic [WIDTH-1:0] win_q [c_TAPS];
    logic [WIDTH-1:0] win_d [c_TAPS];

    logic [WIDTH-1:0] w_lb1_tap;
    logic [WIDTH-1:0] w_lb2_tap;
    logic             w_pix_ready;
    logic             w_pix_acc;
    logic             w_win_take;

    // A new pixel may enter whenever the single output slot is free or being emptied
    assign w_pix_ready = (state_q == ST_STREAM) && (!win_valid_q || win_ready);
    assign w_pix_acc   = w_pix_ready && pix_valid;
    assign w_win_take  = win_valid_q && win_ready;

    // Row r-1: fed by the pixel leaving the bottom window row, so the tap lines up with column c
    conv_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W - 1)
    ) u_lb_r1 (
        .clk  (clk),
        .push (w_pix_acc),
        .din  (win_q[tap_index(2, 2)]),
        .tap  (w_lb1_tap)
    );

    // Row r-2: chained from the middle window row
    conv_line_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W - 1)
    ) u_lb_r2 (
        .clk  (clk),
        .push (w_pix_acc),
        .din  (win_q[tap_index(1, 2)]),
        .tap  (w_lb2_tap)
    );

    // Sequencer next state: weight loading, raster position and end-of-frame detection
    always_comb begin
        state_d      = state_q;
        w_cnt_d      = w_cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        for (int k = 0; k < c_TAPS; k++) begin
            wgt_d[k] = wgt_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD_W;
                    w_cnt_d = '0;
                end else if (frame_start) begin
                    state_d = ST_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_LOAD_W: begin
                if (w_valid) begin
                    for (int k = 0; k < c_TAPS; k++) begin
                        if (w_cnt_q == WCW'(k)) begin
                            wgt_d[k] = w_data;
                        end
                    end
                    if (w_cnt_q == c_W_LAST) begin
                        state_d = ST_IDLE;
                        w_cnt_d = '0;
                    end else begin
                        w_cnt_d = w_cnt_q + WCW'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (w_pix_acc) begin
                    if (col_q == c_COL_LAST) begin
                        col_d = '0;
                        if (row_q == c_ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final window can still be pending here
                if (w_win_take) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window shift and output slot: shift on every accept, present only unpadded windows
    always_comb begin
        win_valid_d = win_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        for (int k = 0; k < c_TAPS; k++) begin
            win_d[k] = win_q[k];
        end

        if (w_win_take) begin
            win_valid_d = 1'b0;
        end

        if (w_pix_acc) begin
            for (int r = 0; r < 3; r++) begin
                win_d[tap_index(r, 0)] = win_q[tap_index(r, 1)];
                win_d[tap_index(r, 1)] = win_q[tap_index(r, 2)];
            end
            win_d[tap_index(0, 2)] = w_lb2_tap;
            win_d[tap_index(1, 2)] = w_lb1_tap;
            win_d[tap_index(2, 2)] = pix_data;

            if ((row_q >= c_ROW_TWO) && (col_q >= c_COL_TWO)) begin
                win_valid_d = 1'b1;
                out_row_d   = row_q - c_ROW_TWO;
                out_col_d   = col_q - c_COL_TWO;
            end
        end
    end

    // State, counters, weights and window registers; reset aborts any activity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            w_cnt_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < c_TAPS; k++) begin
                wgt_q[k] <= '0;
                win_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            w_cnt_q      <= w_cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            for (int k = 0; k < c_TAPS; k++) begin
                wgt_q[k] <= wgt_d[k];
                win_q[k] <= win_d[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < c_TAPS; k++) begin : g_pack
            assign win_a[WIDTH*k +: WIDTH] = win_q[k];
            assign win_b[WIDTH*k +: WIDTH] = wgt_q[k];
        end
    endgenerate

    assign w_ready    = (state_q == ST_LOAD_W);
    assign busy       = (state_q != ST_IDLE);
    assign pix_ready  = w_pix_ready;
    assign win_valid  = win_valid_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
//==============================================================================
// Module  : tb_conv_window_ctrl
// Brief   : Self-checking bench for conv_window_ctrl (IMG_W=5, IMG_H=4, WIDTH=9)
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_window_ctrl;

    localparam int WIDTH = 9;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               load_start = 1'b0;
    logic               frame_start = 1'b0;
    logic               w_valid = 1'b0;
    logic [WIDTH-1:0]   w_data = '0;
    logic               w_ready;
    logic               pix_valid = 1'b0;
    logic [WIDTH-1:0]   pix_data = '0;
    logic               pix_ready;
    logic               win_valid;
    logic               win_ready = 1'b0;
    logic [9*WIDTH-1:0] win_a;
    logic [9*WIDTH-1:0] win_b;
    logic [RW-1:0]      out_row;
    logic [CW-1:0]      out_col;
    logic               busy;
    logic               frame_done;

    int n_vec = 0;
    int n_err = 0;
    logic [9*WIDTH-1:0] exp_wb = '0;

    conv_window_ctrl #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .frame_start (frame_start),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_a       (win_a),
        .win_b       (win_b),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Weight load: values 1..9 or random, optional w_valid gaps. Starts/ends at posedge+1.
    task automatic load_weights(input bit randw, input bit gaps);
        int n;
        int cyc;
        logic [WIDTH-1:0] v;
        n = 0;
        cyc = 0;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        while (n < 9 && cyc < 200) begin
            w_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            v = randw ? WIDTH'($urandom_range(0, 511)) : WIDTH'(n + 1);
            w_data = w_valid ? v : WIDTH'($urandom);
            @(negedge clk);
            check_eq("w_ready", 128'(w_ready), 128'(1));
            if (w_valid && w_ready) begin
                exp_wb[WIDTH*n +: WIDTH] = w_data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        w_valid = 1'b0;
        @(negedge clk);
        check_eq("w_ready_drop", 128'(w_ready), 128'(0));
        check_eq("load_busy", 128'(busy), 128'(0));
        check_eq("win_b", 128'(win_b), 128'(exp_wb));
        @(posedge clk); #1;
    endtask

    // One frame against a queue of windows derived from the pixel array.
    // gap_mode: 0 full rate, 1 every other clk, 2 random. stall_win: window index held 4 clks.
    task automatic run_frame(input bit ramp, input int gap_mode, input int stall_win,
                             input bit rand_ready, input bit poke);
        logic [WIDTH-1:0]   pix [NPIX];
        logic [9*WIDTH-1:0] q_a [$];
        int                 q_r [$];
        int                 q_c [$];
        logic [9*WIDTH-1:0] a;
        logic [9*WIDTH-1:0] prev_a;
        int prev_r, prev_c;
        int idx, cyc, taken, stall_left;
        bit done, fd_exp, lat_exp, held, stall_done;

        for (int i = 0; i < NPIX; i++) begin
            pix[i] = ramp ? WIDTH'(i) : WIDTH'($urandom_range(0, 511));
        end
        for (int r = 0; r <= IMG_H - 3; r++) begin
            for (int c = 0; c <= IMG_W - 3; c++) begin
                a = '0;
                for (int k = 0; k < 9; k++) begin
                    a[WIDTH*k +: WIDTH] = pix[(r + k / 3) * IMG_W + c + k % 3];
                end
                q_a.push_back(a);
                q_r.push_back(r);
                q_c.push_back(c);
            end
        end

        idx = 0; cyc = 0; taken = 0; stall_left = 0;
        done = 0; fd_exp = 0; lat_exp = 0; held = 0; stall_done = 0;
        prev_a = '0; prev_r = 0; prev_c = 0;

        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;

        while (!done && cyc < 400) begin
            pix_valid = (idx < NPIX) && ((gap_mode == 0) ||
                        (gap_mode == 1 && (cyc % 2) == 0) ||
                        (gap_mode == 2 && $urandom_range(0, 1) == 1));
            pix_data = pix_valid ? pix[idx] : WIDTH'($urandom);
            if (win_valid && taken == stall_win && !stall_done) begin
                stall_left = 4;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            load_start  = poke && (cyc == 3);
            frame_start = poke && (cyc == 3);
            w_valid     = poke && (cyc == 3);
            w_data      = WIDTH'($urandom);

            @(negedge clk);
            check_eq("frame_done", 128'(frame_done), 128'(fd_exp));
            if (lat_exp) check_eq("latency", 128'(win_valid), 128'(1));
            if (held) begin
                check_eq("hold_a", 128'(win_a), 128'(prev_a));
                check_eq("hold_row", 128'(out_row), 128'(prev_r));
                check_eq("hold_col", 128'(out_col), 128'(prev_c));
            end
            if (win_valid && !win_ready) check_eq("skid_pr", 128'(pix_ready), 128'(0));
            else if (idx < NPIX) check_eq("tput_pr", 128'(pix_ready), 128'(1));
            if (idx == NPIX) check_eq("drain_pr", 128'(pix_ready), 128'(0));
            if (frame_done) begin
                check_eq("idle_busy", 128'(busy), 128'(0));
                done = 1;
            end

            fd_exp = 0; lat_exp = 0; held = 0;
            if (pix_valid && pix_ready) begin
                if ((idx / IMG_W) >= 2 && (idx % IMG_W) >= 2) lat_exp = 1;
                idx++;
            end
            if (win_valid) begin
                if (win_ready) begin
                    if (q_a.size() == 0) begin
                        check_eq("extra_win", 128'(1), 128'(0));
                    end else begin
                        check_eq("win_a", 128'(win_a), 128'(q_a[0]));
                        check_eq("out_row", 128'(out_row), 128'(q_r[0]));
                        check_eq("out_col", 128'(out_col), 128'(q_c[0]));
                        check_eq("win_b_live", 128'(win_b), 128'(exp_wb));
                        void'(q_a.pop_front());
                        void'(q_r.pop_front());
                        void'(q_c.pop_front());
                        taken++;
                        if (q_a.size() == 0) fd_exp = 1;
                    end
                end else begin
                    held = 1;
                    prev_a = win_a;
                    prev_r = int'(out_row);
                    prev_c = int'(out_col);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end

        pix_valid = 1'b0; load_start = 1'b0; frame_start = 1'b0; w_valid = 1'b0;
        check_eq("frame_end", 128'(done), 128'(1));
        check_eq("win_count", 128'(taken), 128'(NWIN));
        check_eq("pix_count", 128'(idx), 128'(NPIX));
        check_eq("wgt_keep", 128'(win_b), 128'(exp_wb));
    endtask

    // Abort a frame with reset once a window is pending.
    task automatic reset_mid_stream();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        win_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            pix_valid = 1'b1;
            pix_data  = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        check_eq("pre_rst_valid", 128'(win_valid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_win_valid", 128'(win_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_win_b", 128'(win_b), 128'(0));
        check_eq("rst_win_a", 128'(win_a), 128'(0));
        check_eq("rst_pix_ready", 128'(pix_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        exp_wb = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", 128'(frame_done), 128'(0));
            check_eq("rst_idle", 128'(busy), 128'(0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_win_valid", 128'(win_valid), 128'(0));
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_win_b", 128'(win_b), 128'(0));
        check_eq("reset_win_a", 128'(win_a), 128'(0));
        check_eq("reset_pix_ready", 128'(pix_ready), 128'(0));
        check_eq("reset_w_ready", 128'(w_ready), 128'(0));
        check_eq("reset_frame_done", 128'(frame_done), 128'(0));
        check_eq("reset_pos", 128'({out_row, out_col}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        load_weights(1'b0, 1'b1);               // weights 1..9 with gaps
        run_frame(1'b1, 0, -1, 1'b0, 1'b0);     // full rate
        run_frame(1'b1, 0, 1, 1'b0, 1'b0);      // stall at window (0,1)
        run_frame(1'b1, 0, -1, 1'b0, 1'b1);     // start pulses while streaming
        run_frame(1'b1, 0, -1, 1'b0, 1'b0);     // second frame reuses weights
        run_frame(1'b1, 1, -1, 1'b0, 1'b0);     // pix_valid every other clk
        for (int i = 0; i < 4; i++) begin
            load_weights(1'b1, 1'($urandom_range(0, 1)));
            run_frame(1'b0, 2, $urandom_range(0, NWIN - 1), 1'b1, 1'b0);
        end
        reset_mid_stream();
        load_weights(1'b1, 1'b1);
        run_frame(1'b0, 2, -1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
